// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Bit counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return $clog2((width < 2) ? 2 : width);
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder built from two half adders and an OR for the carry.
module full_adder_1bit (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic ha0_s, ha0_c, ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign sum   = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;
  assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell reused per bit.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_q, carry_d;
  logic             carry_load;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  full_adder_1bit u_fa (
    .sum  (fa_s),
    .cout (fa_c),
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the initial carry.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // New sum bit enters at the MSB; after WIDTH shifts the word is aligned.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_next = fa_s;
  end else begin : g_sum_wn
    assign sum_next = {fa_s, sum_sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b_load;
          carry_d  = carry_load;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sum_sr_d = sum_next;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // in_ready is gated by rst_n so it drops the instant reset asserts.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_sr_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench for serial_adder_fsm: WIDTH=8 and WIDTH=1 instances.
// Subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] a, b, sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  // WIDTH=1 instance
  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub1;
`endif

  serial_adder_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder_fsm #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0] q8[$];   // {cout, sum}
  logic [1:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance: result pops on handshake, hold checked on stall.
  logic [8:0] held8;
  bit         held8_v = 0;
  always @(negedge clk) begin
    logic [8:0] exp;
    if (!rst_n) begin
      held8_v = 0;
    end else if (out_valid) begin
      if (held8_v) begin
        checks++;
        if ({cout, sum} !== held8) begin
          errors++;
          $display("FAIL hold8: got %h expected %h", {cout, sum}, held8);
        end
      end
      if (out_ready) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL result8_unexpected: got %h expected none", {cout, sum});
        end else begin
          exp = q8.pop_front();
          if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL result8: got cout=%b sum=%h expected cout=%b sum=%h",
                     cout, sum, exp[8], exp[7:0]);
          end else begin
            $display("txn w8: sum=%h cout=%b at %0t", sum, cout, $time);
          end
        end
        held8_v = 0;
      end else begin
        held8   = {cout, sum};
        held8_v = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] exp;
    if (rst_n && out_valid1 && out_ready1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL result1_unexpected: got %b%b expected none", cout1, sum1);
      end else begin
        exp = q1.pop_front();
        if ({cout1, sum1} !== exp) begin
          errors++;
          $display("FAIL result1: got cout=%b sum=%b expected cout=%b sum=%b",
                   cout1, sum1, exp[1], exp[0]);
        end else begin
          $display("txn w1: sum=%b cout=%b at %0t", sum1, cout1, $time);
        end
      end
    end
  end

  // Drive one request (called #1 after a posedge while IDLE) and drop in_valid after accept.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic sv, input bit expect_result, input logic [8:0] exp);
    in_valid = 1'b1;
    a = av; b = bv; cin = cv;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub requested in add-only build");
`endif
    if (expect_result) q8.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; bounded.
  task automatic wait_out8(input int lat);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency8", k, lat);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; out_ready1 = 1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 0; sub1 = 0;
`endif
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_in_ready1", in_ready1, 1);
    @(posedge clk); #1;

    // FF + 01 + 0 -> 00, cout 1
    out_ready = 1;
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 1, {1'b1, 8'h00});
    check("busy_shift", busy, 1);
    wait_out8(8);
    @(posedge clk); #1;
    check("ready_after_hs", in_ready, 1);
    check("valid_after_hs", out_valid, 0);

    // 3C + 5A + 1 -> 97, stalled 5 cycles with in_valid pulses
    out_ready = 0;
    issue8(8'h3C, 8'h5A, 1'b1, 1'b0, 1, {1'b0, 8'h97});
    wait_out8(8);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    check("stall_release", out_valid, 0);

    // A5 + 0F with in_valid held high: second op (00 + 0F) waits for IDLE
    in_valid = 1; a = 8'hA5; b = 8'h0F; cin = 0;
    q8.push_back({1'b0, 8'hB4});
    @(posedge clk); #1;
    a = 8'h00;
    wait_out8(8);
    @(posedge clk); #1;
    check("second_waits_idle", busy, 0);
    q8.push_back({1'b0, 8'h0F});
    @(posedge clk); #1;
    in_valid = 0;
    check("second_accepted", busy, 1);
    wait_out8(8);
    @(posedge clk); #1;

    // Reset in the 4th SHIFT cycle: immediate clear, op abandoned
    issue8(8'h12, 8'h34, 1'b0, 1'b0, 0, 9'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    issue8(8'h01, 8'h01, 1'b0, 1'b0, 1, {1'b0, 8'h02});
    wait_out8(8);
    @(posedge clk); #1;

    // WIDTH=1: 1 + 1 + 1 -> sum 1, cout 1 after one edge
    in_valid1 = 1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    q1.push_back(2'b11);
    @(posedge clk); #1;
    in_valid1 = 0;
    begin
      int k = 0;
      while (!out_valid1 && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      check("latency1", k, 1);
    end
    @(posedge clk); #1;

`ifdef SERIAL_ADDER_SUB_EN
    issue8(8'h05, 8'h07, 1'b0, 1'b1, 1, {1'b0, 8'hFE});
    wait_out8(8);
    @(posedge clk); #1;
    issue8(8'h07, 8'h05, 1'b1, 1'b1, 1, {1'b1, 8'h02});
    wait_out8(8);
    @(posedge clk); #1;
    sub = 0;
`endif

    begin
      int k = 0;
      while ((q8.size() != 0 || q1.size() != 0) && k < 50) begin
        @(posedge clk);
        k++;
      end
      check("scoreboard_drained", q8.size() + q1.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
